melody_seq: RTL and testbench
=============================

MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 SHALL have parameter PITCH_W, default 9, width of the pitch divider value.
REQ-002 SHALL have parameter DUR_W, default 13, width of the note duration in fs ticks.
REQ-003 SHALL have parameter DEPTH, default 32, note memory entries; AW = clog2(DEPTH).
REQ-004 SHALL have parameter FS_DIV, default 1250, clk cycles per fs tick (10 MHz -> 8 kHz).
REQ-005 SHALL have parameter GAP_TICKS, default 100, silent fs ticks between notes (see Configuration).
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port wr_en, input, 1, note memory write strobe.
REQ-009 SHALL have port wr_addr, input, AW, write address.
REQ-010 SHALL have port wr_pitch, input, PITCH_W, pitch value; 0 = rest.
REQ-011 SHALL have port wr_dur, input, DUR_W, duration in fs ticks.
REQ-012 SHALL have port len, input, AW+1, number of notes to play; sampled at start.
REQ-013 SHALL have port loop_en, input, 1, replay from note 0 after last note; sampled at every wrap.
REQ-014 SHALL have port start, input, 1, begin playback pulse.
REQ-015 SHALL have port stop, input, 1, abort playback pulse.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port pitch_out, output, PITCH_W, divider value for the downstream clkgen; 0 when silent.
REQ-018 SHALL have port gate, output, 1, high while a non-rest note sounds.
REQ-019 SHALL have port note_strobe, output, 1, one-cycle pulse on the first PLAY cycle of every note, rests included.
REQ-020 SHALL have port note_idx, output, AW, index of the current note.
REQ-021 SHALL have port done, output, 1, one-cycle pulse when non-looping playback completes.

Function
REQ-022 SHALL implement the states IDLE, LOAD, PLAY and GAP.
REQ-023 SHALL write note memory on wr_en in any state; memory read is synchronous and performed in LOAD; same-cycle read and write to one address returns the old data.
REQ-024 IDLE: start with len != 0 and stop low SHALL latch len_eff = min(len, DEPTH), set idx = 0 and enter LOAD; start with len == 0 SHALL be ignored.
REQ-025 LOAD SHALL last exactly 1 cycle with pitch_out = 0 and gate = 0, then enter PLAY.
REQ-026 PLAY SHALL drive pitch_out = mem pitch and gate = (pitch != 0); the fs divider restarts at PLAY entry, so a note lasts exactly max(dur, 1) * FS_DIV clk cycles; dur = 0 SHALL be treated as 1.
REQ-027 At note end, with idx < len_eff-1: idx SHALL increment, then the block enters GAP if enabled, otherwise LOAD.
REQ-028 At note end, with idx == len_eff-1 and loop_en = 1: idx SHALL become 0, then the block enters GAP or LOAD.
REQ-029 At note end, with idx == len_eff-1 and loop_en = 0: the block SHALL pulse done and return to IDLE in the next cycle.
REQ-030 Stop SHALL take priority over start and over note-end; stop in any state SHALL go to IDLE next cycle with pitch_out = 0, gate = 0 and no done pulse.
REQ-031 Start while busy SHALL be ignored.
REQ-032 Writes during playback SHALL take effect when the addressed note is next loaded.
REQ-033 Tick and duration counters SHALL be sized to never wrap inside a note.

Reset
REQ-034 Reset SHALL set state IDLE, busy = 0, pitch_out = 0, gate = 0, note_strobe = 0, note_idx = 0, done = 0 and clear all counters.
REQ-035 Reset SHALL NOT clear note memory; contents are undefined after power-up until written.
REQ-036 Reset mid-playback SHALL override everything and reach the reset values the cycle after it is sampled.

Configuration
REQ-037 With macro MELODY_SEQ_GAP_EN defined, GAP SHALL hold pitch_out = 0 and gate = 0 for exactly GAP_TICKS * FS_DIV cycles between notes, including the loop wrap, then enter LOAD; no GAP follows the final note of non-looping playback.
REQ-038 Without MELODY_SEQ_GAP_EN, GAP SHALL be absent and note end SHALL go directly to LOAD.

Verification (FS_DIV=4, DEPTH=8, GAP disabled unless stated)
REQ-039 Write {pitch 177 dur 2, pitch 0 dur 1, pitch 133 dur 3} and start with len=3 -> note_strobe at three note starts, pitch_out 177 for 8 cycles, 0 with gate=0 for 4 cycles, 133 for 12 cycles, done pulses once, busy falls.
REQ-040 Same notes with loop_en=1 -> after note 2, note_idx returns to 0 and 177 replays; clearing loop_en ends at the next wrap with done.
REQ-041 Stop asserted together with start, and stop asserted mid-note -> the block stays or returns to IDLE the next cycle, with no done pulse.
REQ-042 len=0 start -> busy stays 0; len=12 -> plays 8 notes; dur=0 entry -> lasts 4 cycles.
REQ-043 Reset asserted during PLAY -> all outputs 0 next cycle; start then replays from note 0 using the retained memory.
REQ-044 MELODY_SEQ_GAP_EN defined with GAP_TICKS=2 -> 8 silent cycles between notes and at the loop wrap, none after the final note.

Source files
------------

// File: rtl/melody_seq.sv
// melody_seq: plays a table of {pitch, duration} notes into a downstream pitch clock generator.
// Optional silent gap between notes is compiled in when MELODY_SEQ_GAP_EN is defined.
module melody_seq #(
  parameter int PITCH_W   = 9,
  parameter int DUR_W     = 13,
  parameter int DEPTH     = 32,
  parameter int FS_DIV    = 1250,
  parameter int GAP_TICKS = 100,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PITCH_W-1:0] wr_pitch,
  input  logic [DUR_W-1:0]   wr_dur,
  input  logic [AW:0]        len,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic [PITCH_W-1:0] pitch_out,
  output logic               gate,
  output logic               note_strobe,
  output logic [AW-1:0]      note_idx,
  output logic               done
);

  localparam int TW     = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int GW     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  // One counter serves both note duration and gap length, so it takes the wider of the two.
  localparam int CW     = (DUR_W > GW) ? DUR_W : GW;
  localparam int MEM_N  = 1 << AW;
  localparam int WORD_W = PITCH_W + DUR_W;

  localparam logic [TW-1:0] TICK_LAST = TW'(FS_DIV - 1);
  localparam logic [AW:0]   DEPTH_CAP = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

`ifdef MELODY_SEQ_GAP_EN
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam state_t        AFTER_NOTE = state_t'((GAP_TICKS > 0) ? GAP : LOAD);
`else
  localparam state_t        AFTER_NOTE = LOAD;
`endif

  logic [WORD_W-1:0]  mem [MEM_N];

  state_t             state_r;
  logic [AW:0]        len_eff_r;
  logic [TW-1:0]      tick_r;
  logic [CW-1:0]      cnt_r;
  logic [DUR_W-1:0]   note_dur_r;

  logic [WORD_W-1:0]  rd_word_s;
  logic [PITCH_W-1:0] rd_pitch_s;
  logic [DUR_W-1:0]   rd_dur_s;
  logic [DUR_W-1:0]   rd_dur_eff_s;
  logic [AW:0]        len_eff_s;
  logic               tick_end_s;
  logic               dur_end_s;
  logic               note_last_s;

  // Note memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_pitch, wr_dur};
    end
  end

  // Memory word decode, length clamp and counter terminal conditions.
  always_comb begin
    rd_word_s  = mem[note_idx];
    rd_pitch_s = rd_word_s[WORD_W-1:DUR_W];
    rd_dur_s   = rd_word_s[DUR_W-1:0];
    if (rd_dur_s == DUR_W'(0)) begin
      rd_dur_eff_s = DUR_W'(1);
    end else begin
      rd_dur_eff_s = rd_dur_s;
    end
    if (len > DEPTH_CAP) begin
      len_eff_s = DEPTH_CAP;
    end else begin
      len_eff_s = len;
    end
    tick_end_s  = (tick_r == TICK_LAST);
    dur_end_s   = (cnt_r == CW'(note_dur_r - DUR_W'(1)));
    note_last_s = ({1'b0, note_idx} == (len_eff_r - (AW+1)'(1)));
  end

  // Sequencer FSM with registered outputs; stop outranks start and note end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_eff_r   <= (AW+1)'(0);
      tick_r      <= TW'(0);
      cnt_r       <= CW'(0);
      note_dur_r  <= DUR_W'(0);
      busy        <= 1'b0;
      pitch_out   <= PITCH_W'(0);
      gate        <= 1'b0;
      note_strobe <= 1'b0;
      note_idx    <= AW'(0);
      done        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if (stop) begin
        state_r   <= IDLE;
        tick_r    <= TW'(0);
        cnt_r     <= CW'(0);
        busy      <= 1'b0;
        pitch_out <= PITCH_W'(0);
        gate      <= 1'b0;
        note_idx  <= AW'(0);
      end else begin
        case (state_r)
          IDLE: begin
            if (start && (len != (AW+1)'(0))) begin
              len_eff_r <= len_eff_s;
              note_idx  <= AW'(0);
              busy      <= 1'b1;
              state_r   <= LOAD;
            end
          end

          LOAD: begin
            pitch_out   <= rd_pitch_s;
            gate        <= (rd_pitch_s != PITCH_W'(0));
            note_dur_r  <= rd_dur_eff_s;
            note_strobe <= 1'b1;
            tick_r      <= TW'(0);
            cnt_r       <= CW'(0);
            state_r     <= PLAY;
          end

          PLAY: begin
            if (tick_end_s) begin
              tick_r <= TW'(0);
              if (dur_end_s) begin
                cnt_r     <= CW'(0);
                pitch_out <= PITCH_W'(0);
                gate      <= 1'b0;
                if (!note_last_s) begin
                  note_idx <= note_idx + AW'(1);
                  state_r  <= AFTER_NOTE;
                end else if (loop_en) begin
                  note_idx <= AW'(0);
                  state_r  <= AFTER_NOTE;
                end else begin
                  note_idx <= AW'(0);
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_r  <= IDLE;
                end
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end

`ifdef MELODY_SEQ_GAP_EN
          GAP: begin
            if (tick_end_s) begin
              tick_r <= TW'(0);
              if (cnt_r == GAP_LAST) begin
                cnt_r   <= CW'(0);
                state_r <= LOAD;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
`endif

          default: begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            pitch_out <= PITCH_W'(0);
            gate      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: directed and randomized checks of melody_seq against a per-cycle expectation queue.
// Honours MELODY_SEQ_GAP_EN so the same bench covers both builds.
module tb_melody_seq;

  localparam int PW    = 9;
  localparam int DW    = 13;
  localparam int DEPTH = 8;
  localparam int FS    = 4;
  localparam int GT    = 2;
  localparam int AW    = 3;
`ifdef MELODY_SEQ_GAP_EN
  localparam int GAP_CYC = GT * FS;
`else
  localparam int GAP_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_pitch = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW:0]   len = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy, gate, note_strobe, done;
  logic [PW-1:0] pitch_out;
  logic [AW-1:0] note_idx;

  always #5 clk = ~clk;

  melody_seq #(.PITCH_W(PW), .DUR_W(DW), .DEPTH(DEPTH), .FS_DIV(FS), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch),
    .wr_dur(wr_dur), .len(len), .loop_en(loop_en), .start(start), .stop(stop),
    .busy(busy), .pitch_out(pitch_out), .gate(gate), .note_strobe(note_strobe),
    .note_idx(note_idx), .done(done)
  );

  typedef struct {
    bit busy;
    int pitch;
    bit strobe;
    bit done;
    bit chk_idx;
    int idx;
    bit is_load;
    bit note_end;
  } exp_t;

  exp_t q[$];
  exp_t e_cur;
  int   m_pitch [DEPTH];
  int   m_dur   [DEPTH];
  int   m_idx, m_len;
  bit   chk_en = 1'b0;
  bit   cmp_ok;
  int   vectors = 0;
  int   miscompares = 0;
  bit   meas = 1'b0;
  int   cnt_strobe, cnt_done, cnt_busy, cnt_177, cnt_133, cnt_99;

  function automatic exp_t mk(bit b, int p, bit s, bit d, bit ci, int i, bit ld, bit ne);
    exp_t e;
    e.busy = b; e.pitch = p; e.strobe = s; e.done = d;
    e.chk_idx = ci; e.idx = i; e.is_load = ld; e.note_end = ne;
    return e;
  endfunction

  // A note plays max(dur,1)*FS cycles; the first cycle strobes and the last carries the decision.
  task automatic push_note();
    int d;
    int n;
    d = (m_dur[m_idx] == 0) ? 1 : m_dur[m_idx];
    n = d * FS;
    for (int k = 0; k < n; k++)
      q.push_back(mk(1'b1, m_pitch[m_idx], k == 0, 1'b0, 1'b1, m_idx, 1'b0, k == n - 1));
  endtask

  task automatic push_next();
    for (int k = 0; k < GAP_CYC; k++) q.push_back(mk(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
  endtask

  task automatic model_step();
    exp_t cur;
    cur = e_cur;
    if (reset) begin
      q.delete();
      e_cur  = mk(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      chk_en = 1'b1;
    end else if (stop) begin
      q.delete();
      e_cur = mk(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    end else begin
      if (cur.is_load) begin
        push_note();
      end else if (cur.note_end) begin
        if (m_idx < m_len - 1) begin
          m_idx++;
          push_next();
        end else if (loop_en) begin
          m_idx = 0;
          push_next();
        end else begin
          q.push_back(mk(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0));
        end
      end else if (q.size() == 0 && start && len != 0) begin
        m_len = (int'(len) > DEPTH) ? DEPTH : int'(len);
        m_idx = 0;
        q.push_back(mk(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
      end
      if (q.size() > 0) e_cur = q.pop_front();
      else e_cur = mk(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    end
    // The memory read above sees the old word when a write hits the same edge.
    if (wr_en) begin
      m_pitch[wr_addr] = int'(wr_pitch);
      m_dur[wr_addr]   = int'(wr_dur);
    end
  endtask

  initial begin
    e_cur = mk(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp_ok = (busy === e_cur.busy) && (pitch_out === PW'(e_cur.pitch)) &&
               (gate === (e_cur.pitch != 0)) && (note_strobe === e_cur.strobe) &&
               (done === e_cur.done);
      if (e_cur.chk_idx && (note_idx !== AW'(e_cur.idx))) cmp_ok = 1'b0;
      vectors++;
      if (!cmp_ok) begin
        miscompares++;
        $display("FAIL outputs t=%0t: busy=%b pitch=%0d gate=%b strobe=%b done=%b idx=%0d; required busy=%b pitch=%0d gate=%b strobe=%b done=%b idx=%0d(chk %b)",
                 $time, busy, pitch_out, gate, note_strobe, done, note_idx,
                 e_cur.busy, e_cur.pitch, e_cur.pitch != 0, e_cur.strobe, e_cur.done, e_cur.idx, e_cur.chk_idx);
      end
    end
    if (meas) begin
      cnt_strobe += int'(note_strobe);
      cnt_done   += int'(done);
      cnt_busy   += int'(busy);
      cnt_177    += int'(pitch_out == 9'd177);
      cnt_133    += int'(pitch_out == 9'd133);
      cnt_99     += int'(pitch_out == 9'd99);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_meas();
    cnt_strobe = 0; cnt_done = 0; cnt_busy = 0; cnt_177 = 0; cnt_133 = 0; cnt_99 = 0;
    meas = 1'b1;
  endtask

  task automatic write_note(int a, int p, int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_pitch = PW'(p); wr_dur = DW'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(int l);
    len = (AW+1)'(l); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    check({name, "_idle_timeout"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_pitch", int'(pitch_out), 0);
    check("rst_idx", int'(note_idx), 0);

    write_note(0, 177, 2);
    write_note(1, 0, 1);
    write_note(2, 133, 3);
    for (int i = 3; i < DEPTH; i++) write_note(i, 40 + i, 1);

    // Basic three-note melody.
    clear_meas();
    pulse_start(3);
    wait_idle("basic", 300);
    cyc();
    meas = 1'b0;
    check("basic_strobes", cnt_strobe, 3);
    check("basic_done", cnt_done, 1);
    check("basic_177", cnt_177, 8);
    check("basic_133", cnt_133, 12);
    check("basic_busy", cnt_busy, 27 + 2 * GAP_CYC);

    // Looping, then release the loop.
    loop_en = 1'b1;
    clear_meas();
    pulse_start(3);
    n = 0;
    while (cnt_strobe < 4 && n < 300) begin cyc(); n++; end
    check("loop_strobe_timeout", int'(cnt_strobe >= 4), 1);
    loop_en = 1'b0;
    wait_idle("loop", 300);
    cyc();
    meas = 1'b0;
    check("loop_strobes", cnt_strobe, 6);
    check("loop_done", cnt_done, 1);
    check("loop_177", cnt_177, 16);

    // Stop with start, and stop mid-note.
    clear_meas();
    len = 4'd3; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    check("stop_start_busy", int'(busy), 0);
    pulse_start(3);
    for (int i = 0; i < 6; i++) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_mid_busy", int'(busy), 0);
    check("stop_mid_pitch", int'(pitch_out), 0);
    for (int i = 0; i < 4; i++) cyc();
    meas = 1'b0;
    check("stop_no_done", cnt_done, 0);

    // len = 0 ignored, len = 12 clamps to DEPTH.
    pulse_start(0);
    check("len0_busy", int'(busy), 0);
    clear_meas();
    pulse_start(12);
    wait_idle("len12", 600);
    cyc();
    meas = 1'b0;
    check("len12_strobes", cnt_strobe, 8);

    // Zero duration is one tick.
    write_note(0, 99, 0);
    clear_meas();
    pulse_start(1);
    wait_idle("dur0", 100);
    meas = 1'b0;
    check("dur0_99", cnt_99, 4);
    check("dur0_busy", cnt_busy, 5);
    write_note(0, 177, 2);

    // Reset mid-play, then replay from retained memory.
    pulse_start(3);
    for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rstplay_busy", int'(busy), 0);
    check("rstplay_gate", int'(gate), 0);
    check("rstplay_idx", int'(note_idx), 0);
    clear_meas();
    pulse_start(3);
    wait_idle("replay", 300);
    meas = 1'b0;
    check("replay_177", cnt_177, 8);
    check("replay_133", cnt_133, 12);

    // Randomized traffic; the per-cycle model does the checking.
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_pitch = ($urandom_range(0, 2) == 0) ? PW'(0) : PW'($urandom_range(1, 511));
      wr_dur   = DW'($urandom_range(0, 3));
      start    = ($urandom_range(0, 7) == 0);
      len      = (AW+1)'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      stop     = ($urandom_range(0, 149) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      cyc();
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b0; loop_en = 1'b0;
    wait_idle("random_end", 1000);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
